dvp_frame_normalizer: RTL and testbench



---
 rtl/dvp_frame_normalizer.sv | 237 +++++++++++++++++++++++
 tb/tb_dvp_frame_normalizer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_normalizer.sv
// Normalises raw DVP capture into fixed-geometry frames for the DDR write port:
// pads/truncates lines to IMG_H, drops lines past IMG_V, and gates on a clean frame start.
module dvp_frame_normalizer #(
    parameter int IMG_H      = 1920,
    parameter int IMG_V      = 1080,
    parameter int DATA_WIDTH = 8,
    parameter int PAD_VALUE  = 0,
    parameter int LOAD_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  in_vs,
    input  logic                  in_de,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  err_clr,
    output logic                  out_load,
    output logic                  out_de,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           frame_cnt,
    output logic                  err_short_line,
    output logic                  err_long_line,
    output logic                  err_frame_len,
    output logic                  err_overlap,
    output logic                  busy
);

    localparam logic [11:0] H_MAX     = 12'(IMG_H);
    localparam logic [11:0] H_LAST    = 12'(IMG_H - 1);
    localparam logic [11:0] V_MAX     = 12'(IMG_V);
    localparam logic [12:0] V_MAX_EXT = 13'(IMG_V);
    localparam logic [3:0]  LOAD_LAST = 4'(LOAD_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] PAD_PIX = DATA_WIDTH'(PAD_VALUE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACTIVE,
        PAD,
        DROP
    } state_t;

    state_t                state_reg, state_next;
    logic [11:0]           col_reg, col_next;
    logic [11:0]           row_reg, row_next;
    logic [3:0]            load_cnt_reg, load_cnt_next;
    logic [15:0]           frame_cnt_reg;
    logic                  vs_d_reg, de_d_reg;
    logic                  overlap_reg, overlap_next;
    logic                  out_de_reg, out_de_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  short_reg, long_reg, frame_reg, ovl_reg;

    logic                  vs_rise, de_rise, de_fall;
    logic                  enter_load, do_pad, frame_end;
    logic                  set_short, set_long, set_frame, set_ovl;
    logic                  line_done;
    logic [12:0]           row_eff;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign vs_rise = in_vs & ~vs_d_reg;
    assign de_rise = in_de & ~de_d_reg;
    assign de_fall = ~in_de & de_d_reg;

    // A line that already reached IMG_H but has not seen de_fall still counts as complete.
    assign line_done = (state_reg == ACTIVE) && (col_reg >= H_MAX);
    assign row_eff   = {1'b0, row_reg} + 13'(line_done);

    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        row_next      = row_reg;
        load_cnt_next = load_cnt_reg;
        overlap_next  = overlap_reg;
        out_de_next   = 1'b0;
        out_data_next = out_data_reg;
        enter_load    = 1'b0;
        do_pad        = 1'b0;
        frame_end     = 1'b0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        set_frame     = 1'b0;
        set_ovl       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (vs_rise && enable) begin
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (load_cnt_reg >= LOAD_LAST) begin
                    state_next = ACTIVE;
                end else begin
                    load_cnt_next = load_cnt_reg + 4'd1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                end else if (in_de) begin
                    if (row_reg >= V_MAX) begin
                        set_frame = 1'b1;
                    end else if (col_reg >= H_MAX) begin
                        set_long = 1'b1;
                    end else begin
                        out_de_next   = 1'b1;
                        out_data_next = in_data;
                        col_next      = sat_inc(col_reg);
                    end
                end else if (de_fall && (col_reg != 12'd0)) begin
                    if (col_reg < H_MAX) begin
                        // The de_fall cycle itself carries the first pad pixel.
                        set_short = 1'b1;
                        do_pad    = 1'b1;
                    end else begin
                        row_next = sat_inc(row_reg);
                        col_next = 12'd0;
                    end
                end
            end
            PAD: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                end else begin
                    do_pad = 1'b1;
                    if (de_rise) begin
                        set_ovl      = 1'b1;
                        overlap_next = 1'b1;
                    end
                end
            end
            DROP: begin
                if (vs_rise) begin
                    frame_end = 1'b1;
                end else if (de_fall) begin
                    state_next = ACTIVE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (do_pad) begin
            out_de_next   = 1'b1;
            out_data_next = PAD_PIX;
            if (col_reg >= H_LAST) begin
                row_next     = sat_inc(row_reg);
                col_next     = 12'd0;
                overlap_next = 1'b0;
                // Only discard the overlapping line if it is still running.
                state_next   = ((overlap_reg || de_rise) && in_de) ? DROP : ACTIVE;
            end else begin
                col_next   = sat_inc(col_reg);
                state_next = PAD;
            end
        end

        if (frame_end) begin
            overlap_next = 1'b0;
            if (row_eff != V_MAX_EXT) begin
                set_frame = 1'b1;
            end
            if ((col_reg != 12'd0) && (col_reg < H_MAX)) begin
                set_short = 1'b1;
            end
            if (enable) begin
                enter_load = 1'b1;
            end else begin
                state_next = IDLE;
            end
        end

        if (enter_load) begin
            state_next    = LOAD;
            col_next      = 12'd0;
            row_next      = 12'd0;
            load_cnt_next = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            col_reg       <= 12'd0;
            row_reg       <= 12'd0;
            load_cnt_reg  <= 4'd0;
            frame_cnt_reg <= 16'd0;
            vs_d_reg      <= 1'b0;
            de_d_reg      <= 1'b0;
            overlap_reg   <= 1'b0;
            out_de_reg    <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            load_cnt_reg <= load_cnt_next;
            vs_d_reg     <= in_vs;
            de_d_reg     <= in_de;
            overlap_reg  <= overlap_next;
            out_de_reg   <= out_de_next;
            out_data_reg <= out_data_next;
            if (enter_load) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    // Sticky flags: a new error in the same cycle wins over err_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            short_reg <= 1'b0;
            long_reg  <= 1'b0;
            frame_reg <= 1'b0;
            ovl_reg   <= 1'b0;
        end else begin
            short_reg <= set_short | (short_reg & ~err_clr);
            long_reg  <= set_long  | (long_reg  & ~err_clr);
            frame_reg <= set_frame | (frame_reg & ~err_clr);
            ovl_reg   <= set_ovl   | (ovl_reg   & ~err_clr);
        end
    end

    assign out_load       = (state_reg == LOAD);
    assign busy           = (state_reg != IDLE);
    assign out_de         = out_de_reg;
    assign out_data       = out_data_reg;
    assign frame_cnt      = frame_cnt_reg;
    assign err_short_line = short_reg;
    assign err_long_line  = long_reg;
    assign err_frame_len  = frame_reg;
    assign err_overlap    = ovl_reg;

endmodule

// File: tb/tb_dvp_frame_normalizer.sv
// Directed bench for dvp_frame_normalizer with an 8x4 geometry and a non-zero pad value.
module tb_dvp_frame_normalizer;

    localparam logic [7:0] PADV = 8'hA5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        in_vs = 1'b0;
    logic        in_de = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        err_clr = 1'b0;
    logic        out_load, out_de, busy;
    logic [7:0]  out_data;
    logic [15:0] frame_cnt;
    logic        err_short_line, err_long_line, err_frame_len, err_overlap;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int de_cnt = 0;
    int ld_cnt = 0;
    int de_base, ld_base, q_base;

    dvp_frame_normalizer #(
        .IMG_H(8), .IMG_V(4), .DATA_WIDTH(8), .PAD_VALUE(8'hA5), .LOAD_LEN(4)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .in_vs(in_vs), .in_de(in_de),
        .in_data(in_data), .err_clr(err_clr), .out_load(out_load), .out_de(out_de),
        .out_data(out_data), .frame_cnt(frame_cnt), .err_short_line(err_short_line),
        .err_long_line(err_long_line), .err_frame_len(err_frame_len),
        .err_overlap(err_overlap), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_de) begin
            got_q.push_back(out_data);
            de_cnt++;
        end
        if (out_load) ld_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_vs = 1'b0; in_de = 1'b0; err_clr = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic begin_test;
        de_base = de_cnt;
        ld_base = ld_cnt;
        q_base  = got_q.size();
        exp_q.delete();
    endtask

    task automatic vs_pulse(input logic en);
        enable = en;
        in_vs = 1'b1;
        tick(); tick();
        in_vs = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_line(input int n, input int start, input int gap);
        for (int i = 0; i < n; i++) begin
            in_de = 1'b1;
            in_data = 8'(start + i);
            tick();
        end
        in_de = 1'b0;
        in_data = 8'd0;
        repeat (gap) tick();
    endtask

    task automatic push_exp(input int n, input int start);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(start + i));
    endtask

    task automatic push_pad(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(PADV);
    endtask

    task automatic compare_stream(input string tag, input int exp_ld);
        check({tag, "_de_count"}, 32'(de_cnt - de_base), 32'(exp_q.size()));
        check({tag, "_load_cycles"}, 32'(ld_cnt - ld_base), 32'(exp_ld));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q_base + i < got_q.size())
                check($sformatf("%s_px%0d", tag, i), 32'(got_q[q_base + i]), 32'(exp_q[i]));
            else
                check($sformatf("%s_px%0d_missing", tag, i), 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    task automatic check_errs(input string tag, input logic s, input logic l,
                              input logic f, input logic o);
        check({tag, "_err_short"}, 32'(err_short_line), 32'(s));
        check({tag, "_err_long"}, 32'(err_long_line), 32'(l));
        check({tag, "_err_frame"}, 32'(err_frame_len), 32'(f));
        check({tag, "_err_overlap"}, 32'(err_overlap), 32'(o));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_out_de", 32'(out_de), 0);
        check("rst_out_load", 32'(out_load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        do_reset();

        // T1: clean 4x8 frame with ramp 0..31, plus 1-cycle latency probe
        begin_test();
        vs_pulse(1'b1);
        in_de = 1'b1;
        in_data = 8'd0;
        @(negedge clk);
        check("t1_lat_pre_de", 32'(out_de), 0);
        tick();
        @(negedge clk);
        check("t1_lat_de", 32'(out_de), 1);
        check("t1_lat_data", 32'(out_data), 0);
        for (int i = 1; i < 8; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_de = 1'b0;
        repeat (3) tick();
        for (int l = 1; l < 4; l++) send_line(8, 8 * l, 3);
        push_exp(32, 0);
        compare_stream("t1", 4);
        vs_pulse(1'b0);
        check("t1_frame_cnt", 32'(frame_cnt), 1);
        check("t1_busy_idle", 32'(busy), 0);
        check_errs("t1", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2: third line only 5 pixels -> 3 pads
        do_reset();
        begin_test();
        vs_pulse(1'b1);
        send_line(8, 0, 3);
        send_line(8, 8, 3);
        send_line(5, 16, 3);
        send_line(8, 24, 3);
        push_exp(21, 0);
        push_pad(3);
        push_exp(8, 24);
        compare_stream("t2", 4);
        vs_pulse(1'b0);
        check_errs("t2", 1'b1, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t2_clr_short", 32'(err_short_line), 0);

        // T3: 11-pixel line and a 6-line frame
        do_reset();
        begin_test();
        vs_pulse(1'b1);
        send_line(8, 0, 3);
        send_line(11, 16, 3);
        for (int l = 2; l < 6; l++) send_line(8, 16 * l, 3);
        push_exp(8, 0);
        push_exp(8, 16);
        push_exp(8, 32);
        push_exp(8, 48);
        compare_stream("t3", 4);
        vs_pulse(1'b0);
        check("t3_frame_cnt", 32'(frame_cnt), 1);
        check_errs("t3", 1'b0, 1'b1, 1'b1, 1'b0);

        // T4: short line, next line rises 1 cycle after fall -> dropped
        do_reset();
        begin_test();
        vs_pulse(1'b1);
        send_line(8, 0, 3);
        send_line(5, 16, 1);
        send_line(8, 32, 3);
        send_line(8, 48, 3);
        push_exp(8, 0);
        push_exp(5, 16);
        push_pad(3);
        push_exp(8, 48);
        compare_stream("t4", 4);
        vs_pulse(1'b0);
        check_errs("t4", 1'b1, 1'b0, 1'b1, 1'b1);

        // T5: enable low at first vs, rises mid-frame -> nothing until next vs_rise
        do_reset();
        begin_test();
        vs_pulse(1'b0);
        send_line(8, 0, 3);
        send_line(8, 8, 3);
        enable = 1'b1;
        send_line(8, 16, 3);
        send_line(8, 24, 3);
        compare_stream("t5_gated", 0);
        check("t5_gated_frame_cnt", 32'(frame_cnt), 0);
        check("t5_gated_busy", 32'(busy), 0);
        begin_test();
        vs_pulse(1'b1);
        for (int l = 0; l < 4; l++) send_line(8, 8 * l + 64, 3);
        push_exp(32, 64);
        compare_stream("t5", 4);
        vs_pulse(1'b0);
        check("t5_frame_cnt", 32'(frame_cnt), 1);
        check_errs("t5", 1'b0, 1'b0, 1'b0, 1'b0);

        // T6: vs_rise while padding at col 6, then async reset mid-line
        do_reset();
        begin_test();
        vs_pulse(1'b1);
        for (int i = 0; i < 5; i++) begin
            in_de = 1'b1;
            in_data = 8'(i);
            tick();
        end
        in_de = 1'b0;
        tick();
        in_vs = 1'b1;
        @(negedge clk);
        check("t6_pad_de", 32'(out_de), 1);
        check("t6_pad_data", 32'(out_data), 32'(PADV));
        check("t6_load_pre", 32'(out_load), 0);
        tick();
        @(negedge clk);
        check("t6_load_now", 32'(out_load), 1);
        check("t6_pad_stopped", 32'(out_de), 0);
        check("t6_err_short", 32'(err_short_line), 1);
        check("t6_frame_cnt", 32'(frame_cnt), 2);
        in_vs = 1'b0;
        repeat (5) tick();
        push_exp(5, 0);
        push_pad(1);
        compare_stream("t6", 8);
        in_de = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(100 + i);
            tick();
        end
        @(negedge clk);
        check("t6_midline_de", 32'(out_de), 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_out_de", 32'(out_de), 0);
        check("t6_rst_out_data", 32'(out_data), 0);
        check("t6_rst_out_load", 32'(out_load), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_frame_cnt", 32'(frame_cnt), 0);
        check("t6_rst_err_short", 32'(err_short_line), 0);
        in_de = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
